// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiplier / divider, one bit per clock.
//   MUL: {ResHi,ResLo} = OpA * OpB (shift-add, WIDTH cycles)
//   DIV: ResLo = OpA / OpB, ResHi = OpA % OpB (restoring, WIDTH cycles)
//   DIV by zero completes immediately: ResLo = all ones, ResHi = OpA, DivZero = 1.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Start, Op           request (sampled in IDLE only), 0 = MUL / 1 = DIV
//   OpA, OpB            operands (register-file Data1 / Data2)
//   ResLo, ResHi        results, held from Done until the next Done
//   Busy, Done, DivZero status; Done is a one-cycle pulse
module muldiv_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic             Op,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic [WIDTH-1:0] ResLo,
   output logic [WIDTH-1:0] ResHi,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               op_q, op_nxt;
   logic [WIDTH-1:0]   opd_q, opd_nxt;       // multiplicand (MUL) or divisor (DIV)
   logic [WIDTH-1:0]   acc_hi, acc_hi_nxt;   // partial product high / partial remainder
   logic [WIDTH-1:0]   acc_lo, acc_lo_nxt;   // multiplier bits / dividend -> quotient
   logic [WIDTH-1:0]   res_lo_nxt, res_hi_nxt;
   logic               done_nxt, dz_nxt;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   iter_hi, iter_lo;

   // One iteration of the selected algorithm on the working registers
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd_q} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opd_q});
      div_diff  = div_ge ? (div_shift - {1'b0, opd_q}) : div_shift;
      if (op_q) begin
         // remainder is always below the divisor, so WIDTH bits suffice
         iter_hi = div_diff[WIDTH-1:0];
         iter_lo = {acc_lo[WIDTH-2:0], div_ge};
      end else begin
         // carry out of the add shifts into the top of the high half
         iter_hi = mul_sum[WIDTH:1];
         iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // Next-state and output logic
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      op_nxt     = op_q;
      opd_nxt    = opd_q;
      acc_hi_nxt = acc_hi;
      acc_lo_nxt = acc_lo;
      res_lo_nxt = ResLo;
      res_hi_nxt = ResHi;
      done_nxt   = 1'b0;
      dz_nxt     = DivZero;
      case (state)
         IDLE: begin
            if (Start) begin
               dz_nxt = 1'b0;
               if (Op && (OpB == '0)) begin
                  // divide by zero bypasses RUN entirely
                  res_lo_nxt = '1;
                  res_hi_nxt = OpA;
                  dz_nxt     = 1'b1;
                  done_nxt   = 1'b1;
               end else begin
                  op_nxt     = Op;
                  opd_nxt    = Op ? OpB : OpA;
                  acc_hi_nxt = '0;
                  acc_lo_nxt = Op ? OpA : OpB;
                  cnt_nxt    = '0;
                  state_nxt  = RUN;
               end
            end
         end
         RUN: begin
            acc_hi_nxt = iter_hi;
            acc_lo_nxt = iter_lo;
            cnt_nxt    = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               res_hi_nxt = iter_hi;
               res_lo_nxt = iter_lo;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= 1'b0;
         opd_q   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         ResLo   <= '0;
         ResHi   <= '0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         op_q    <= op_nxt;
         opd_q   <= opd_nxt;
         acc_hi  <= acc_hi_nxt;
         acc_lo  <= acc_lo_nxt;
         ResLo   <= res_lo_nxt;
         ResHi   <= res_hi_nxt;
         Done    <= done_nxt;
         DivZero <= dz_nxt;
      end
   end

   assign Busy = (state == RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH = 16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_muldiv_unit;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         Start;
   logic         Op;
   logic [W-1:0] OpA;
   logic [W-1:0] OpB;
   logic [W-1:0] ResLo;
   logic [W-1:0] ResHi;
   logic         Busy;
   logic         Done;
   logic         DivZero;

   int           checks   = 0;
   int           failures = 0;
   int           lat;
   int           idle_viol;
   bit           busy_seen;
   bit           overlap;
   logic [W-1:0] lo_mid;
   logic         dz_first;
   logic         busy_pre;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .Start   (Start),
      .Op      (Op),
      .OpA     (OpA),
      .OpB     (OpB),
      .ResLo   (ResLo),
      .ResHi   (ResHi),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for Done. lat counts falling edges
   // after the accepting rising edge; -1 means Done never arrived.
   task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit immediate, input bit disturb);
      if (!immediate) @(negedge clk);
      Start = 1'b1;
      Op    = op;
      OpA   = a;
      OpB   = b;
      @(posedge clk);
      lat       = -1;
      busy_seen = 1'b0;
      overlap   = 1'b0;
      lo_mid    = 'x;
      dz_first  = 1'bx;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            Start    = 1'b0;
            dz_first = DivZero;
         end
         if (disturb && i == 5) begin
            Start = 1'b1;
            Op    = 1'b0;
            OpA   = 16'hFFFF;
            OpB   = 16'h0002;
         end
         if (disturb && i == 6) Start = 1'b0;
         if (i == 8) lo_mid = ResLo;
         if (Busy) busy_seen = 1'b1;
         if (Busy && Done) overlap = 1'b1;
         if (Done) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      Start = 1'b0;
      Op    = 1'b0;
      OpA   = '0;
      OpB   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_reslo",   32'(ResLo),   32'h0);
      check("rst_reshi",   32'(ResHi),   32'h0);
      check("rst_busy",    32'(Busy),    32'h0);
      check("rst_done",    32'(Done),    32'h0);
      check("rst_divzero", 32'(DivZero), 32'h0);
      rst = 1'b0;

      // MUL 0x1234 * 0x0010
      run_op(1'b0, 16'h1234, 16'h0010, 1'b0, 1'b0);
      check("mul1_lat",     32'(lat),       32'd17);
      check("mul1_hi",      32'(ResHi),     32'h0001);
      check("mul1_lo",      32'(ResLo),     32'h2340);
      check("mul1_dz",      32'(DivZero),   32'h0);
      check("mul1_busy",    32'(busy_seen), 32'h1);
      check("mul1_overlap", 32'(overlap),   32'h0);

      // MUL 0xFFFF * 0xFFFF, then back-to-back 0x0000 * 0xBEEF from the Done cycle
      run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      check("mulmax_hi", 32'(ResHi), 32'hFFFE);
      check("mulmax_lo", 32'(ResLo), 32'h0001);
      run_op(1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
      check("b2b_lat",    32'(lat),    32'd17);
      check("b2b_lo_mid", 32'(lo_mid), 32'h0001);
      check("mulzero_hi", 32'(ResHi),  32'h0000);
      check("mulzero_lo", 32'(ResLo),  32'h0000);

      // DIV 100 / 7 with an ignored Start and operand changes mid-RUN
      run_op(1'b1, 16'd100, 16'd7, 1'b0, 1'b1);
      check("div1_lat",     32'(lat),     32'd17);
      check("div1_lo",      32'(ResLo),   32'h000E);
      check("div1_hi",      32'(ResHi),   32'h0002);
      check("div1_dz",      32'(DivZero), 32'h0);
      check("div1_overlap", 32'(overlap), 32'h0);
      idle_viol = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (Busy || Done) idle_viol++;
      end
      check("no_pending_op", 32'(idle_viol), 32'h0);

      // DIV 5 / 9
      run_op(1'b1, 16'h0005, 16'h0009, 1'b0, 1'b0);
      check("div2_lo", 32'(ResLo), 32'h0000);
      check("div2_hi", 32'(ResHi), 32'h0005);

      // DIV 0x1234 / 0
      run_op(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
      check("dz_lat",  32'(lat),       32'd1);
      check("dz_lo",   32'(ResLo),     32'hFFFF);
      check("dz_hi",   32'(ResHi),     32'h1234);
      check("dz_flag", 32'(DivZero),   32'h1);
      check("dz_busy", 32'(busy_seen), 32'h0);
      repeat (3) @(negedge clk);
      check("dz_hold_flag", 32'(DivZero), 32'h1);
      check("dz_hold_done", 32'(Done),    32'h0);
      check("dz_hold_lo",   32'(ResLo),   32'hFFFF);

      // Next accepted Start clears DivZero
      run_op(1'b0, 16'h0003, 16'h0005, 1'b0, 1'b0);
      check("dz_clear_start", 32'(dz_first), 32'h0);
      check("mul35_lo",       32'(ResLo),    32'h000F);
      check("mul35_dz",       32'(DivZero),  32'h0);

      // Leave nonzero state behind, then abort a MUL with reset at RUN cycle 8
      run_op(1'b1, 16'hABCD, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      Start = 1'b1;
      Op    = 1'b0;
      OpA   = 16'h00FF;
      OpB   = 16'h00FF;
      @(posedge clk);
      busy_pre = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) Start = 1'b0;
         if (i == 7) busy_pre = Busy;
         if (i == 8) rst = 1'b1;
      end
      @(negedge clk);
      check("abort_busy_before", 32'(busy_pre), 32'h1);
      check("abort_busy",    32'(Busy),    32'h0);
      check("abort_done",    32'(Done),    32'h0);
      check("abort_reslo",   32'(ResLo),   32'h0);
      check("abort_reshi",   32'(ResHi),   32'h0);
      check("abort_divzero", 32'(DivZero), 32'h0);
      rst = 1'b0;

      // First Start right after reset release: MUL 3 * 4
      run_op(1'b0, 16'h0003, 16'h0004, 1'b1, 1'b0);
      check("post_rst_lat", 32'(lat),   32'd17);
      check("post_rst_lo",  32'(ResLo), 32'h000C);
      check("post_rst_hi",  32'(ResHi), 32'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
